// File: rtl/hack_pkg.sv
// hack_pkg: sequencer state encoding and Hack instruction bit positions
package hack_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_EXEC   = 3'd5
  } state_t;
  localparam int I_BIT  = 15;
  localparam int A_BIT  = 12;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
endpackage

// File: rtl/hack_commit_decode.sv
// hack_commit_decode: register and PC commit strobes, active only while i_en is high
module hack_commit_decode (
  input  logic i_en,
  input  logic i_is_c,
  input  logic i_dest_a,
  input  logic i_dest_d,
  input  logic i_jump_taken,
  output logic o_load_a_en,
  output logic o_load_d_en,
  output logic o_pc_inc,
  output logic o_pc_load
);
  logic w_pc_load;
  assign w_pc_load   = i_en & i_is_c & i_jump_taken;
  assign o_pc_load   = w_pc_load;
  assign o_pc_inc    = i_en & ~w_pc_load;
  assign o_load_a_en = i_en & (~i_is_c | i_dest_a);
  assign o_load_d_en = i_en & i_is_c & i_dest_d;
endmodule

// File: rtl/hack_sequencer.sv
// hack_sequencer: multi-cycle fetch/decode/memory/execute control FSM for a Hack CPU
module hack_sequencer
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        mdr_load,
  input  logic        jump_taken,
  output logic        load_a_en,
  output logic        load_d_en,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] retire_cnt,
  output logic [2:0]  state
);
  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [15:0] r_retire_cnt;
  logic        w_exec;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  w_next = imem_ack ? ST_DECODE : ST_FETCH;
      ST_DECODE: w_next = !r_ir[I_BIT] ? ST_EXEC : r_ir[A_BIT] ? ST_MEM_RD : r_ir[DEST_M] ? ST_MEM_WR : ST_EXEC;
      ST_MEM_RD: w_next = !dmem_ack ? ST_MEM_RD : r_ir[DEST_M] ? ST_MEM_WR : ST_EXEC;
      ST_MEM_WR: w_next = dmem_ack ? ST_EXEC : ST_MEM_WR;
      ST_EXEC:   w_next = run ? ST_FETCH : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  // requests are pure state decodes so a stray ack can never raise them
  always_comb begin
    imem_req = r_state == ST_FETCH;
    dmem_req = r_state == ST_MEM_RD || r_state == ST_MEM_WR;
    dmem_we  = r_state == ST_MEM_WR;
    mdr_load = r_state == ST_MEM_RD && dmem_ack;
    w_exec   = r_state == ST_EXEC;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ir         <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (r_state == ST_FETCH && imem_ack) r_ir <= imem_rdata;
      if (r_state == ST_EXEC) r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  hack_commit_decode u_commit (
    .i_en         (w_exec),
    .i_is_c       (r_ir[I_BIT]),
    .i_dest_a     (r_ir[DEST_A]),
    .i_dest_d     (r_ir[DEST_D]),
    .i_jump_taken (jump_taken),
    .o_load_a_en  (load_a_en),
    .o_load_d_en  (load_d_en),
    .o_pc_inc     (pc_inc),
    .o_pc_load    (pc_load)
  );
  assign ir         = r_ir;
  assign retire_cnt = r_retire_cnt;
  assign state      = r_state;
endmodule

// File: tb/tb_hack_sequencer.sv
// tb_hack_sequencer: directed vector table, reset/wrap sequences and randomized instructions vs. an instruction-level model
module tb_hack_sequencer;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, MEM_RD = 3'd3, MEM_WR = 3'd4, EXEC = 3'd5;
  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, dmem_ack, jump_taken;
  logic [15:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, mdr_load, load_a_en, load_d_en, pc_inc, pc_load;
  logic [15:0] ir, retire_cnt;
  logic [2:0]  state;
  logic [42:0] act;
  int          n_pass = 0, n_tot = 0;
  logic [15:0] m_ir = 16'h0, m_cnt = 16'h0;
  logic        m_idle = 1'b1;
  int          lat, nm;
  logic [3:0]  xs;
  logic [15:0] cnt0;

  typedef struct {
    logic [15:0] ins;
    int          iw, rw, ww;
    logic        jt;
    int          lat;
    logic [3:0]  strb;
    int          nmdr;
  } vec_t;
  vec_t tv[8];

  hack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .mdr_load(mdr_load),
    .jump_taken(jump_taken), .load_a_en(load_a_en), .load_d_en(load_d_en),
    .pc_inc(pc_inc), .pc_load(pc_load), .retire_cnt(retire_cnt), .state(state)
  );

  always #5 clk = ~clk;
  assign act = {state, imem_req, dmem_req, dmem_we, mdr_load, load_a_en, load_d_en, pc_inc, pc_load, ir, retire_cnt};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction
  // expected observable vector for a state, from the per-state output rules
  function automatic logic [42:0] ev(input logic [2:0] st, input logic mdr, input logic [3:0] strb);
    return {st, st == FETCH, st == MEM_RD || st == MEM_WR, st == MEM_WR, mdr, strb, m_ir, m_cnt};
  endfunction

  task automatic chk(input string name, input logic [42:0] got, input logic [42:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic tick(input string name, input logic r, input logic ia, input logic da,
                      input logic [15:0] rd, input logic jt, input logic [2:0] est,
                      input logic emdr, input logic [3:0] estr);
    @(negedge clk);
    run = r; imem_ack = ia; dmem_ack = da; imem_rdata = rd; jump_taken = jt;
    #1;
    chk(name, act, ev(est, emdr, estr));
  endtask

  // one whole instruction: phase lengths follow from the opcode bits and chosen ack delays
  task automatic do_instr(input logic [15:0] ins, input int iw, input int rw, input int ww,
                          input int idle_extra, input logic jt, input logic ra,
                          output int o_lat, output logic [3:0] o_xs, output int o_nmdr);
    logic c, rdp, wrp, pl;
    logic [3:0] s;
    c = ins[15]; rdp = c & ins[12]; wrp = c & ins[3]; pl = c & jt;
    s = {~c | ins[5], c & ins[4], ~pl, pl};
    o_lat = 0; o_nmdr = 0;
    if (m_idle) begin
      for (int k = 0; k < idle_extra; k++) tick("idle_hold", 1'b0, rb(), rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
      tick("idle_go", 1'b1, rb(), rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
    end
    for (int k = 0; k <= iw; k++) begin
      tick("fetch", rb(), k == iw, rb(), (k == iw) ? ins : r16(), rb(), FETCH, 1'b0, 4'b0);
      o_lat += int'(state != IDLE);
    end
    m_ir = ins;
    tick("decode", rb(), rb(), rb(), r16(), rb(), DECODE, 1'b0, 4'b0);
    o_lat += int'(state != IDLE);
    if (rdp)
      for (int k = 0; k <= rw; k++) begin
        tick("mem_rd", rb(), rb(), k == rw, r16(), rb(), MEM_RD, k == rw, 4'b0);
        o_lat += int'(state != IDLE);
        o_nmdr += int'(mdr_load);
      end
    if (wrp)
      for (int k = 0; k <= ww; k++) begin
        tick("mem_wr", rb(), rb(), k == ww, r16(), rb(), MEM_WR, 1'b0, 4'b0);
        o_lat += int'(state != IDLE);
      end
    tick("exec", ra, rb(), rb(), r16(), jt, EXEC, 1'b0, s);
    o_lat += int'(state != IDLE);
    o_xs = {load_a_en, load_d_en, pc_inc, pc_load};
    m_cnt = m_cnt + 16'd1;
    m_idle = !ra;
  endtask

  initial begin
    tv[0] = '{16'h0007, 0, 0, 0, 1'b0, 3, 4'b1010, 0};
    tv[1] = '{16'hFC10, 0, 2, 0, 1'b0, 6, 4'b0110, 1};
    tv[2] = '{16'hE7CF, 0, 0, 0, 1'b1, 4, 4'b0001, 0};
    tv[3] = '{16'hEC10, 0, 0, 0, 1'b0, 3, 4'b0110, 0};
    tv[4] = '{16'hFC38, 0, 0, 0, 1'b1, 5, 4'b1101, 1};
    tv[5] = '{16'h1038, 0, 0, 0, 1'b1, 3, 4'b1010, 0};
    tv[6] = '{16'h0100, 3, 0, 0, 1'b0, 6, 4'b1010, 0};
    tv[7] = '{16'hE020, 1, 0, 2, 1'b1, 4, 4'b1001, 0};

    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0; jump_taken = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      run = 1'b1; imem_ack = rb(); dmem_ack = rb(); imem_rdata = r16();
      #1;
      chk("reset_hold", act, ev(IDLE, 1'b0, 4'b0));
    end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("reset_release", act, ev(IDLE, 1'b0, 4'b0));

    for (int i = 0; i < 8; i++) begin
      do_instr(tv[i].ins, tv[i].iw, tv[i].rw, tv[i].ww, 0, tv[i].jt, 1'b1, lat, xs, nm);
      chk($sformatf("vec%0d_latency", i), 43'(lat), 43'(tv[i].lat));
      chk($sformatf("vec%0d_strobes", i), 43'(xs), 43'(tv[i].strb));
      chk($sformatf("vec%0d_mdr_pulses", i), 43'(nm), 43'(tv[i].nmdr));
    end

    // run dropped while the write is outstanding
    cnt0 = m_cnt;
    do_instr(16'hE7CF, 0, 0, 2, 0, 1'b1, 1'b0, lat, xs, nm);
    tick("stop_idle", 1'b0, rb(), rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
    chk("stop_retire", 43'(retire_cnt), 43'(cnt0 + 16'd1));
    tick("stop_idle2", 1'b0, 1'b1, 1'b1, r16(), rb(), IDLE, 1'b0, 4'b0);

    // reset coinciding with a fetch ack
    tick("rf_go", 1'b1, 1'b0, rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hABCD;
    #1;
    chk("rf_fetch", act, ev(FETCH, 1'b0, 4'b0));
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    m_ir = 16'h0; m_cnt = 16'h0;
    #1;
    chk("rf_after_reset", act, ev(IDLE, 1'b0, 4'b0));
    tick("rf_late_ack", 1'b0, 1'b1, 1'b1, 16'h5678, rb(), IDLE, 1'b0, 4'b0);

    // reset while a data read is waiting
    tick("rd_go", 1'b1, rb(), rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
    tick("rd_fetch", rb(), 1'b1, rb(), 16'hFC10, rb(), FETCH, 1'b0, 4'b0);
    m_ir = 16'hFC10;
    tick("rd_decode", rb(), rb(), rb(), r16(), rb(), DECODE, 1'b0, 4'b0);
    tick("rd_wait", rb(), rb(), 1'b0, r16(), rb(), MEM_RD, 1'b0, 4'b0);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; dmem_ack = 1'b1;
    m_ir = 16'h0; m_cnt = 16'h0;
    #1;
    chk("rd_after_reset", act, ev(IDLE, 1'b0, 4'b0));
    tick("rd_late_ack", 1'b0, rb(), 1'b1, r16(), rb(), IDLE, 1'b0, 4'b0);

    // counter wrap from a preloaded all-ones value
    @(negedge clk);
    force dut.r_retire_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_retire_cnt;
    m_cnt = 16'hFFFF;
    #1;
    chk("preload", 43'(retire_cnt), 43'(16'hFFFF));
    do_instr(16'h0042, 0, 0, 0, 0, 1'b0, 1'b0, lat, xs, nm);
    tick("wrap_idle", 1'b0, rb(), rb(), r16(), rb(), IDLE, 1'b0, 4'b0);
    chk("wrap_cnt", 43'(retire_cnt), 43'(16'h0000));

    for (int i = 0; i < 200; i++)
      do_instr(r16(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), rb(), $urandom_range(0, 3) != 0, lat, xs, nm);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
